// File: rtl/rk_sdspi.sv
// SD card SPI byte engine (mode 0): one CPU write to reg1 shifts a full byte out on MOSI
// and the card's reply in from MISO; reg0 holds chip select and the slow/fast clock choice.
module rk_sdspi #(
    parameter int SLOW_DIV = 63,
    parameter int FAST_DIV = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       addr,
    input  logic [7:0] idata,
    input  logic       we_n,
    output logic [7:0] odata,
    output logic       sd_cs_n,
    output logic       sd_sck,
    output logic       sd_mosi,
    input  logic       sd_miso
);

    // state | meaning: IDLE | sck=0, mosi=1 ; LOW | sck=0, bit on mosi ; HIGH | sck=1, miso sampled
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t     state;
    logic       we_n_q;
    logic       access;
    logic       cs;
    logic       fast;
    logic       busy;
    logic [7:0] rx;
    logic [7:0] shreg;
    logic [7:0] div_q;
    logic [7:0] cnt;
    logic [7:0] start_div;
    logic [2:0] bitcnt;

    assign access    = we_n_q & ~we_n;
    assign start_div = fast ? 8'(FAST_DIV) : 8'(SLOW_DIV);
    assign odata     = addr ? rx : {busy, 5'b0, fast, cs};
    assign sd_cs_n   = ~cs;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            we_n_q  <= 1'b1;
            cs      <= 1'b0;
            fast    <= 1'b0;
            busy    <= 1'b0;
            rx      <= 8'hFF;
            shreg   <= 8'h00;
            div_q   <= 8'h01;
            cnt     <= 8'h00;
            bitcnt  <= 3'd0;
            sd_sck  <= 1'b0;
            sd_mosi <= 1'b1;
        end else begin
            we_n_q <= we_n;
            if (access && !addr) begin
                cs   <= idata[0];
                fast <= idata[1];
            end
            case (state)
                IDLE: begin
                    if (access && addr) begin
                        state   <= LOW;
                        busy    <= 1'b1;
                        shreg   <= idata;
                        sd_mosi <= idata[7];
                        div_q   <= start_div;
                        cnt     <= start_div - 8'd1;
                        bitcnt  <= 3'd0;
                    end
                end
                LOW: begin
                    if (cnt == 8'd0) begin
                        // MISO shifts in at the LSB; the next MOSI bit moves up to shreg[7]
                        sd_sck <= 1'b1;
                        shreg  <= {shreg[6:0], sd_miso};
                        cnt    <= div_q - 8'd1;
                        state  <= HIGH;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HIGH: begin
                    if (cnt == 8'd0) begin
                        sd_sck <= 1'b0;
                        cnt    <= div_q - 8'd1;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            rx      <= shreg;
                            busy    <= 1'b0;
                            sd_mosi <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            sd_mosi <= shreg[7];
                            state   <= LOW;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rk_sdspi.sv
// Directed bench for rk_sdspi: per-cycle SCK/MOSI/busy waveform checks against a timing
// model derived from the half-period divider, with a MISO stimulus that plays a reply byte.
module tb_rk_sdspi;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       addr = 1'b0;
    logic [7:0] idata = 8'h00;
    logic       we_n = 1'b1;
    logic [7:0] odata;
    logic       sd_cs_n;
    logic       sd_sck;
    logic       sd_mosi;
    logic       sd_miso = 1'b1;

    int checks = 0;
    int failures = 0;

    rk_sdspi #(.SLOW_DIV(63), .FAST_DIV(2)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .idata(idata), .we_n(we_n),
        .odata(odata), .sd_cs_n(sd_cs_n), .sd_sck(sd_sck), .sd_mosi(sd_mosi),
        .sd_miso(sd_miso)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One write access; returns at the negedge just after the access is registered (k=0).
    task automatic wr(input logic a, input logic [7:0] d);
        @(negedge clk);
        addr = a; idata = d; we_n = 1'b0;
        @(negedge clk);
        we_n = 1'b1; addr = 1'b0;
    endtask

    // Watches one transfer cycle by cycle; k=0 is the first cycle after the start access.
    task automatic observe(input int div, input logic [7:0] tx, input logic [7:0] resp,
                           input logic [7:0] prev_rx, input int hold_k, input int fastw_k,
                           input int tail, output int sck_err, output int mosi_err,
                           output int busy_err, output int rd_err, output int edges,
                           output int fall_k);
        logic prev_sck, exp_sck, exp_mosi, exp_busy, in_hold;
        logic [7:0] txv, rsv;
        txv = tx; rsv = resp;
        sck_err = 0; mosi_err = 0; busy_err = 0; rd_err = 0; edges = 0; fall_k = -1;
        prev_sck = 1'b0;
        for (int k = 0; k < 16 * div + tail + 40; k++) begin
            sd_miso = (k < 16 * div) ? rsv[7 - (k / (2 * div))] : 1'b1;
            if (hold_k >= 0 && k == hold_k) begin addr = 1'b1; idata = 8'h55; we_n = 1'b0; end
            if (hold_k >= 0 && k == hold_k + 10) begin we_n = 1'b1; addr = 1'b0; end
            if (fastw_k >= 0 && k == fastw_k) begin addr = 1'b0; idata = 8'h03; we_n = 1'b0; end
            if (fastw_k >= 0 && k == fastw_k + 1) we_n = 1'b1;
            #1;
            exp_sck  = (k < 16 * div) && ((k / div) % 2 == 1);
            exp_mosi = (k < 16 * div) ? txv[7 - (k / (2 * div))] : 1'b1;
            exp_busy = (k < 16 * div);
            if (sd_sck !== exp_sck) sck_err++;
            if (sd_mosi !== exp_mosi) mosi_err++;
            if (sd_sck === 1'b1 && prev_sck === 1'b0) edges++;
            prev_sck = sd_sck;
            in_hold = (hold_k >= 0) && (k >= hold_k) && (k < hold_k + 10);
            if (in_hold) begin
                if (odata !== prev_rx) rd_err++;
            end else begin
                if (odata[7] !== exp_busy) busy_err++;
                if (odata[7] === 1'b0 && fall_k < 0) fall_k = k;
            end
            if (fall_k >= 0 && k >= fall_k + tail) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; we_n = 1'b1; addr = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (odata !== 8'h00) begin failures++; $display("FAIL reset_reg0 got=%h exp=00", odata); end
        checks++; if (sd_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", sd_cs_n); end
        checks++; if (sd_sck !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", sd_sck); end
        checks++; if (sd_mosi !== 1'b1) begin failures++; $display("FAIL reset_mosi got=%b exp=1", sd_mosi); end
        addr = 1'b1; #1;
        checks++; if (odata !== 8'hFF) begin failures++; $display("FAIL reset_reg1 got=%h exp=FF", odata); end
        addr = 1'b0;
    endtask

    task automatic test_fast_loopback;
        int se, me, be, re, ed, fk;
        wr(1'b0, 8'h03); #1;
        checks++; if (odata !== 8'h03) begin failures++; $display("FAIL fast_reg0 got=%h exp=03", odata); end
        checks++; if (sd_cs_n !== 1'b0) begin failures++; $display("FAIL fast_cs_n got=%b exp=0", sd_cs_n); end
        wr(1'b1, 8'hA5);
        observe(2, 8'hA5, 8'h3C, 8'hFF, -1, -1, 5, se, me, be, re, ed, fk);
        checks++; if (se != 0) begin failures++; $display("FAIL fast_sck errors=%0d exp=0", se); end
        checks++; if (me != 0) begin failures++; $display("FAIL fast_mosi errors=%0d exp=0", me); end
        checks++; if (ed != 8) begin failures++; $display("FAIL fast_edges got=%0d exp=8", ed); end
        checks++; if (fk != 32 || be != 0) begin failures++; $display("FAIL fast_busy fall=%0d err=%0d exp fall=32", fk, be); end
        addr = 1'b1; #1;
        checks++; if (odata !== 8'h3C) begin failures++; $display("FAIL fast_rx got=%h exp=3C", odata); end
        addr = 1'b0;
    endtask

    task automatic test_slow;
        int se, me, be, re, ed, fk;
        wr(1'b0, 8'h01);
        wr(1'b1, 8'hFF);
        observe(63, 8'hFF, 8'h00, 8'h3C, -1, -1, 2, se, me, be, re, ed, fk);
        checks++; if (se != 0 || me != 0) begin failures++; $display("FAIL slow_wave sck_err=%0d mosi_err=%0d exp=0", se, me); end
        checks++; if (fk != 1008 || be != 0) begin failures++; $display("FAIL slow_busy fall=%0d err=%0d exp fall=1008", fk, be); end
        addr = 1'b1; #1;
        checks++; if (odata !== 8'h00) begin failures++; $display("FAIL slow_rx got=%h exp=00", odata); end
        addr = 1'b0;
    endtask

    task automatic test_busy_write;
        int se, me, be, re, ed, fk;
        wr(1'b0, 8'h03);
        wr(1'b1, 8'hC3);
        observe(2, 8'hC3, 8'h5A, 8'h00, 5, -1, 40, se, me, be, re, ed, fk);
        checks++; if (se != 0 || me != 0 || ed != 8) begin failures++; $display("FAIL busy_wr_wave sck_err=%0d mosi_err=%0d edges=%0d exp 0/0/8", se, me, ed); end
        checks++; if (re != 0) begin failures++; $display("FAIL busy_wr_rxhold errors=%0d exp=0", re); end
        checks++; if (fk != 32 || be != 0) begin failures++; $display("FAIL busy_wr_nostart fall=%0d err=%0d exp fall=32 err=0", fk, be); end
        addr = 1'b1; #1;
        checks++; if (odata !== 8'h5A) begin failures++; $display("FAIL busy_wr_rx got=%h exp=5A", odata); end
        addr = 1'b0;
    endtask

    task automatic test_fast_change_back_to_back;
        int se, me, be, re, ed, fk;
        wr(1'b0, 8'h01);
        wr(1'b1, 8'h81);
        observe(63, 8'h81, 8'h42, 8'h5A, -1, 100, 0, se, me, be, re, ed, fk);
        checks++; if (se != 0 || me != 0 || fk != 1008) begin failures++; $display("FAIL chg_slow sck_err=%0d mosi_err=%0d fall=%0d exp 0/0/1008", se, me, fk); end
        #1;
        checks++; if (odata !== 8'h03) begin failures++; $display("FAIL chg_reg0 got=%h exp=03", odata); end
        wr(1'b1, 8'h18);
        observe(2, 8'h18, 8'hE7, 8'h42, -1, -1, 2, se, me, be, re, ed, fk);
        checks++; if (se != 0 || me != 0 || fk != 32 || be != 0) begin failures++; $display("FAIL b2b_fast sck_err=%0d mosi_err=%0d fall=%0d busy_err=%0d exp fall=32", se, me, fk, be); end
        addr = 1'b1; #1;
        checks++; if (odata !== 8'hE7) begin failures++; $display("FAIL b2b_rx got=%h exp=E7", odata); end
        addr = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] rsv;
        rsv = 8'h0F;
        wr(1'b1, 8'h96);
        for (int k = 0; k < 18; k++) begin
            sd_miso = rsv[7 - (k / 4)];
            @(negedge clk);
        end
        #1;
        checks++; if (sd_sck !== 1'b1) begin failures++; $display("FAIL mid_edge4 sck got=%b exp=1", sd_sck); end
        reset_n = 1'b0;
        @(negedge clk); #1;
        checks++; if (sd_sck !== 1'b0 || sd_mosi !== 1'b1 || sd_cs_n !== 1'b1) begin failures++; $display("FAIL mid_pins sck=%b mosi=%b cs_n=%b exp 0/1/1", sd_sck, sd_mosi, sd_cs_n); end
        checks++; if (odata !== 8'h00) begin failures++; $display("FAIL mid_reg0 got=%h exp=00", odata); end
        addr = 1'b1; #1;
        checks++; if (odata !== 8'hFF) begin failures++; $display("FAIL mid_rx got=%h exp=FF", odata); end
        addr = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fast_loopback();
        test_slow();
        test_busy_write();
        test_fast_change_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
